// File: rtl/merge_sort_engine.sv
`default_nettype none
// ============================================================================
// Module  : merge_sort_engine
// Purpose : Iterative bottom-up merge sorter returning sorted data and the
//           stable permutation (original index of each sorted element).
// Rev     : 1.0  initial release
// ============================================================================
module merge_sort_engine #(
    parameter int NUM_ELEM = 4,
    parameter int DATA_W   = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   descend,
    input  logic [NUM_ELEM*DATA_W-1:0]             data_in,
    output logic                                   busy,
    output logic                                   done,
    output logic [NUM_ELEM*DATA_W-1:0]             data_out,
    output logic [NUM_ELEM*$clog2(NUM_ELEM)-1:0]   idx_out
);

    localparam int IDX_W  = $clog2(NUM_ELEM);
    localparam int CW     = IDX_W + 1;
    localparam int PASSES = IDX_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_MERGE  = 2'd1;
    localparam logic [1:0] S_FINISH = 2'd2;

    logic [1:0]          state_q,   state_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                desc_q,    desc_d;
    logic                src_sel_q, src_sel_d;
    logic [CW-1:0]       width_q,   width_d;
    logic [CW-1:0]       pass_q,    pass_d;
    logic [CW-1:0]       base_q,    base_d;
    logic [CW-1:0]       lcnt_q,    lcnt_d;
    logic [CW-1:0]       rcnt_q,    rcnt_d;
    logic [IDX_W-1:0]    wptr_q,    wptr_d;

    logic [DATA_W-1:0]   data_a_q [NUM_ELEM];
    logic [DATA_W-1:0]   data_b_q [NUM_ELEM];
    logic [IDX_W-1:0]    tag_a_q  [NUM_ELEM];
    logic [IDX_W-1:0]    tag_b_q  [NUM_ELEM];

    logic [NUM_ELEM*DATA_W-1:0] data_out_q;
    logic [NUM_ELEM*IDX_W-1:0]  idx_out_q;

    logic [IDX_W-1:0]    w_l_addr;
    logic [IDX_W-1:0]    w_r_addr;
    logic                w_l_exh;
    logic                w_r_exh;
    logic [DATA_W-1:0]   w_l_data;
    logic [DATA_W-1:0]   w_r_data;
    logic [IDX_W-1:0]    w_l_tag;
    logic [IDX_W-1:0]    w_r_tag;
    logic                w_take_left;
    logic [DATA_W-1:0]   w_wr_data;
    logic [IDX_W-1:0]    w_wr_tag;
    logic                w_pair_end;
    logic                w_pass_end;

    // Addresses are truncated to IDX_W, so an exhausted side still reads a
    // real register and never produces X; its value is masked by w_*_exh.
    always_comb begin
        w_l_addr = IDX_W'(base_q + lcnt_q);
        w_r_addr = IDX_W'(base_q + width_q + rcnt_q);
        w_l_exh  = (lcnt_q == width_q);
        w_r_exh  = (rcnt_q == width_q);
        w_l_data = src_sel_q ? data_b_q[w_l_addr] : data_a_q[w_l_addr];
        w_r_data = src_sel_q ? data_b_q[w_r_addr] : data_a_q[w_r_addr];
        w_l_tag  = src_sel_q ? tag_b_q[w_l_addr]  : tag_a_q[w_l_addr];
        w_r_tag  = src_sel_q ? tag_b_q[w_r_addr]  : tag_a_q[w_r_addr];
        // Ties go left to keep the sort stable.
        w_take_left = w_r_exh |
                      (~w_l_exh & (desc_q ? (w_l_data >= w_r_data)
                                          : (w_l_data <= w_r_data)));
        w_wr_data  = w_take_left ? w_l_data : w_r_data;
        w_wr_tag   = w_take_left ? w_l_tag  : w_r_tag;
        w_pair_end = ((lcnt_q + rcnt_q) == ((width_q << 1) - CW'(1)));
        w_pass_end = (wptr_q == IDX_W'(NUM_ELEM - 1));
    end

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        desc_d    = desc_q;
        src_sel_d = src_sel_q;
        width_d   = width_q;
        pass_d    = pass_q;
        base_d    = base_q;
        lcnt_d    = lcnt_q;
        rcnt_d    = rcnt_q;
        wptr_d    = wptr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_MERGE;
                    busy_d    = 1'b1;
                    desc_d    = descend;
                    src_sel_d = 1'b0;
                    width_d   = CW'(1);
                    pass_d    = '0;
                    base_d    = '0;
                    lcnt_d    = '0;
                    rcnt_d    = '0;
                    wptr_d    = '0;
                end
            end
            S_MERGE: begin
                wptr_d = wptr_q + IDX_W'(1);
                if (w_take_left) begin
                    lcnt_d = lcnt_q + CW'(1);
                end else begin
                    rcnt_d = rcnt_q + CW'(1);
                end
                if (w_pair_end) begin
                    base_d = base_q + (width_q << 1);
                    lcnt_d = '0;
                    rcnt_d = '0;
                end
                if (w_pass_end) begin
                    wptr_d    = '0;
                    base_d    = '0;
                    src_sel_d = ~src_sel_q;
                    width_d   = width_q << 1;
                    pass_d    = pass_q + CW'(1);
                    if (pass_q == CW'(PASSES - 1)) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            desc_q    <= 1'b0;
            src_sel_q <= 1'b0;
            width_q   <= '0;
            pass_q    <= '0;
            base_q    <= '0;
            lcnt_q    <= '0;
            rcnt_q    <= '0;
            wptr_q    <= '0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            desc_q    <= desc_d;
            src_sel_q <= src_sel_d;
            width_q   <= width_d;
            pass_q    <= pass_d;
            base_q    <= base_d;
            lcnt_q    <= lcnt_d;
            rcnt_q    <= rcnt_d;
            wptr_q    <= wptr_d;
        end
    end

    // After the final swap, src_sel_q points at the bank written last.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ELEM; i++) begin
                data_a_q[i] <= '0;
                data_b_q[i] <= '0;
                tag_a_q[i]  <= '0;
                tag_b_q[i]  <= '0;
            end
            data_out_q <= '0;
            idx_out_q  <= '0;
        end else begin
            if (state_q == S_IDLE && start) begin
                for (int i = 0; i < NUM_ELEM; i++) begin
                    data_a_q[i] <= data_in[i*DATA_W +: DATA_W];
                    tag_a_q[i]  <= IDX_W'(i);
                end
            end else if (state_q == S_MERGE) begin
                if (src_sel_q) begin
                    data_a_q[wptr_q] <= w_wr_data;
                    tag_a_q[wptr_q]  <= w_wr_tag;
                end else begin
                    data_b_q[wptr_q] <= w_wr_data;
                    tag_b_q[wptr_q]  <= w_wr_tag;
                end
            end
            if (state_q == S_FINISH) begin
                for (int j = 0; j < NUM_ELEM; j++) begin
                    data_out_q[j*DATA_W +: DATA_W] <= src_sel_q ? data_b_q[j] : data_a_q[j];
                    idx_out_q[j*IDX_W +: IDX_W]    <= src_sel_q ? tag_b_q[j]  : tag_a_q[j];
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign data_out = data_out_q;
    assign idx_out  = idx_out_q;

endmodule
`default_nettype wire

// File: doc/merge_sort_engine.md
Name: merge_sort_engine

Overview:
- Parametrised, iterative bottom-up merge sorter for NUM_ELEM elements of DATA_W bits each. Supports ascending and descending order.
- Returns the sorted values and the stable permutation, i.e. the original index of each sorted element. The BWT suffix-ordering stages need that permutation.
- A parallel block is loaded on start. The engine does log2(NUM_ELEM) merge passes, one element per cycle, using two ping-pong register banks.
- It replaces the fixed 4-byte, FIFO-chained sorting tree.

Parameters:
NUM_ELEM, 4, element count; power of two, >= 2
DATA_W, 8, element width in bits; compared unsigned
IDX_W, $clog2(NUM_ELEM), index width; localparam, not overridable

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; synchronous, active-low (asserted when 0, sampled only on rising edge of clk)
start  input  1  load request; sampled only in IDLE
descend  input  1  sort order; 0 = ascending, 1 = descending; captured with start
data_in  input  NUM_ELEM*DATA_W  element i at data_in[i*DATA_W +: DATA_W]
busy  output  1  high while a sort is in progress
done  output  1  one-cycle pulse; data_out and idx_out are valid and updated
data_out  output  NUM_ELEM*DATA_W  sorted elements, slot j at [j*DATA_W +: DATA_W]
idx_out  output  NUM_ELEM*IDX_W  original index of the element in sorted slot j, at [j*IDX_W +: IDX_W]

Behaviour:
- Reset (rst=0 at an edge):
  - State goes to IDLE.
  - busy=0, done=0, data_out=0, idx_out=0.
  - Both banks and all pointers cleared.
  - Applies mid-sort: the sort is abandoned and no done is produced.
- States: IDLE, MERGE, FINISH.
- IDLE:
  - start=1 at an edge: bank A <= data_in, tags A[i] <= i, order <= descend, run width <= 1, pass <= 0, write pointer <= 0, busy <= 1; go to MERGE.
  - start=0: remain in IDLE.
- MERGE, every cycle writes exactly one element+tag into the destination bank at the write pointer:
  - The source bank holds sorted runs of width w. Adjacent run pairs [b, b+w) and [b+w, b+2w) are merged into [b, b+2w).
  - Take left when right is exhausted, OR left is not exhausted and left <= right (ascending) / left >= right (descending).
  - Ties always take left, so the sort is stable.
  - The left/right pointers advance; after 2w writes, b advances by 2w.
  - After NUM_ELEM writes: swap the bank roles, w <= 2w, pass++.
  - After pass log2(NUM_ELEM) completes: go to FINISH.
- FINISH (one cycle): data_out/idx_out <= final bank, done <= 1, busy <= 0; go to IDLE.
- done is high for exactly one cycle. data_out and idx_out hold until the next done or reset.
- Latency: load at edge k; merge writes at edges k+1 .. k+L, where L = NUM_ELEM*log2(NUM_ELEM); outputs and done are registered at edge k+L+1.
  - NUM_ELEM=4 gives done visible 9 edges after the load edge.
  - NUM_ELEM=8 gives 25 edges.
- A new start may be accepted on the cycle done is high (state is IDLE). Back-to-back throughput is L+2 cycles per block.
- start or descend changes while busy=1 are ignored. data_in is not sampled while busy=1.
- Comparison is unsigned over the full DATA_W. No X may propagate from unused pointer values.

Test Plan:
- Ascending, NUM_ELEM=4, DATA_W=8:
  - Stimulus: data_in = {07,02,09,02} (slots 0..3) -> data_out = {02,02,07,09}, idx_out = {1,3,0,2}.
  - done pulses once, 9 edges after load; busy is high for exactly those cycles.
- Descending, same data: descend=1 -> data_out = {09,07,02,02}, idx_out = {2,0,1,3} (stable order among the equal elements).
- Edge values: all elements = FF -> data_out = {FF,FF,FF,FF}, idx_out = {0,1,2,3}. Input {00,FF,80,7F} ascending -> {00,7F,80,FF}, idx {0,3,2,1}.
- Busy and reset:
  - Start pulsed again and data_in changed while busy -> result reflects the first block only, with a single done.
  - rst=0 at cycle 4 after load -> no done; outputs 0; a new start afterwards completes normally.
- Back-to-back blocks: second start asserted in the done cycle -> second done exactly 10 edges after the first (L+2), both results correct.
- NUM_ELEM=8, DATA_W=16: input {0005,FFFF,0003,0005,0000,1234,0003,0001} ascending -> {0000,0001,0003,0003,0005,0005,1234,FFFF}, idx {4,7,2,6,0,3,5,1}; done 25 edges after load.
- Add a randomized scoreboard against a stable reference sort, covering both modes.
